hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the 5-stage RISC-V pipeline.
//  - Per-operand forwarding selects for EX from EX/MEM and MEM/WB.
//  - Load-use stall FSM with configurable memory latency.
//  - Branch/jump flush control, gating the IF, ID and EX pipeline registers.
// PARAMETERS
//  REG_ADDR_W    5  register address width
//  NUM_SRC       2  source operands per instruction (2 or 3)
//  LOAD_STALL_CY 1  bubbles inserted per load-use hazard (1..7)
// PORTS
//  clk              in   1                  pipeline clock, rising edge
//  rst              in   1                  async reset, active-high
//  id_rs_addr       in   NUM_SRC*REG_ADDR_W source addrs of instruction in ID, operand i at [i*W +: W]
//  id_rs_used       in   NUM_SRC            operand i is read by the ID instruction
//  id_ex_rs_addr    in   NUM_SRC*REG_ADDR_W source addrs of instruction in EX
//  id_ex_rd_addr    in   REG_ADDR_W         dest of instruction in EX
//  id_ex_mem_read   in   1                  instruction in EX is a load
//  ex_mem_rd_addr   in   REG_ADDR_W         dest in EX/MEM
//  ex_mem_reg_write in   1                  EX/MEM writes rd
//  mem_wb_rd_addr   in   REG_ADDR_W         dest in MEM/WB
//  mem_wb_reg_write in   1                  MEM/WB writes rd
//  ex_branch_taken  in   1                  redirect resolved in EX this cycle
//  forward          out  2*NUM_SRC          select for operand i at [2i +: 2]
//  pc_write         out  1                  PC may update
//  if_id_write      out  1                  IF/ID may load
//  if_id_flush      out  1                  IF/ID becomes a NOP
//  id_ex_flush      out  1                  ID/EX becomes a bubble
//  stall_active     out  1                  stall FSM is not in IDLE, or is entering a stall
// BEHAVIOUR
//  Forward codes (combinational, per operand): 00 = regfile, 01 = EX/MEM, 10 = MEM/WB, 11 = never driven.
//   - 01 when ex_mem_reg_write, ex_mem_rd != 0 and ex_mem_rd == rs.
//   - Otherwise 10 when the same test holds on MEM/WB.
//   - EX/MEM always has priority. Address 0 is never forwarded.
//  Load-use hazard, hz (combinational): id_ex_mem_read && id_ex_rd != 0 &&
//   there exists i with id_rs_used[i] and id_rs_addr[i] == id_ex_rd.
//  Stall FSM: states IDLE, STALL. Down-counter cnt is 3 bits.
//   - IDLE, hz && !ex_branch_taken:
//     - pc_write = 0, if_id_write = 0, id_ex_flush = 1 in the same cycle.
//     - If LOAD_STALL_CY > 1: next state STALL, cnt = LOAD_STALL_CY - 1.
//     - Else stay in IDLE.
//   - STALL: same outputs as above; cnt decrements each cycle; cnt == 1 -> IDLE next.
//     The hz input is ignored while in STALL.
//   - IDLE, no hz: pc_write = 1, if_id_write = 1, id_ex_flush = 0.
//  Flush:
//   - ex_branch_taken -> if_id_flush = 1 and id_ex_flush = 1 for that cycle.
//   - pc_write = 1 and if_id_write = 1 so the redirect target loads.
//   - Overrides any stall. The FSM returns to IDLE next cycle and cnt is cleared.
//   - A branch never coincides with a load in EX; flush still wins if it does.
//  stall_active = (state == STALL) || (state == IDLE && hz && !ex_branch_taken).
//  Reset (async, rst high): state IDLE, cnt = 0.
//   - While rst is high: forward = 0, pc_write = 0, if_id_write = 0,
//     if_id_flush = 1, id_ex_flush = 1, stall_active = 0.
//   - Reset mid-stall abandons the stall; the first cycle after release is IDLE.
//  Latency: forwarding and stall decision are zero-cycle combinational; only the FSM is registered.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds three out ports, 32-bit each, wrapping, reset to 0 asynchronously.
//   - stat_stall_cycles: +1 per cycle with stall_active.
//   - stat_flushes:      +1 per cycle with ex_branch_taken.
//   - stat_fwd_events:   +1 per cycle in which any forward code is non-zero.
//  HAZARD_STATS_EN undefined: no ports, no counters; behaviour otherwise identical.
// TESTING
//  1. rs = {1,2}, EX/MEM rd = 3, MEM/WB rd = 4, both writing -> forward = 0000.
//  2. rs0 = 5, EX/MEM rd = 5 and MEM/WB rd = 5, both writing -> op0 = 01 (EX priority).
//     rs1 = 0 with rd = 0 -> op1 = 00.
//  3. LOAD_STALL_CY = 3, load rd = 7 in EX, ID rs1 = 7 used:
//     - Exactly 3 cycles of pc_write = 0, id_ex_flush = 1.
//     - 4th cycle pc_write = 1.
//  4. Same hazard with id_rs_used = 0 for that operand -> no stall, pc_write = 1.
//  5. LOAD_STALL_CY = 3, ex_branch_taken pulsed in 2nd stall cycle:
//     - That cycle: if_id_flush = 1, id_ex_flush = 1, pc_write = 1.
//     - Next cycle: state IDLE, stall_active = 0.
//  6. rst asserted asynchronously mid-stall -> outputs at reset values immediately.
//     After release, IDLE.
//     With HAZARD_STATS_EN, all stat counters read 0.

Source files
------------

// File: rtl/hazard_forward_ctrl_if.sv
// Hazard/forwarding controller bus bundle.
//
// Groups every pipeline-side signal the controller consumes or produces.
//   master : pipeline datapath view (drives hazard inputs, receives controls)
//   slave  : controller view (receives hazard inputs, drives controls)
//
// Signals:
//   id_rs_addr       source addrs of the ID instruction, operand i at [i*W +: W]
//   id_rs_used       operand i is actually read by the ID instruction
//   id_ex_rs_addr    source addrs of the EX instruction
//   id_ex_rd_addr    dest of the EX instruction
//   id_ex_mem_read   EX instruction is a load
//   ex_mem_rd_addr   dest in EX/MEM
//   ex_mem_reg_write EX/MEM writes rd
//   mem_wb_rd_addr   dest in MEM/WB
//   mem_wb_reg_write MEM/WB writes rd
//   ex_branch_taken  redirect resolved in EX this cycle
//   forward          per-operand forward select, operand i at [2i +: 2]
//   pc_write         PC may update
//   if_id_write      IF/ID may load
//   if_id_flush      IF/ID becomes a NOP
//   id_ex_flush      ID/EX becomes a bubble
//   stall_active     load-use stall in progress or starting
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2
);
  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]            id_rs_used;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs_addr;
  logic [REG_ADDR_W-1:0]         id_ex_rd_addr;
  logic                          id_ex_mem_read;
  logic [REG_ADDR_W-1:0]         ex_mem_rd_addr;
  logic                          ex_mem_reg_write;
  logic [REG_ADDR_W-1:0]         mem_wb_rd_addr;
  logic                          mem_wb_reg_write;
  logic                          ex_branch_taken;
  logic [2*NUM_SRC-1:0]          forward;
  logic                          pc_write;
  logic                          if_id_write;
  logic                          if_id_flush;
  logic                          id_ex_flush;
  logic                          stall_active;

  modport master (
    output id_rs_addr, id_rs_used, id_ex_rs_addr, id_ex_rd_addr, id_ex_mem_read,
    output ex_mem_rd_addr, ex_mem_reg_write, mem_wb_rd_addr, mem_wb_reg_write,
    output ex_branch_taken,
    input  forward, pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active
  );

  modport slave (
    input  id_rs_addr, id_rs_used, id_ex_rs_addr, id_ex_rd_addr, id_ex_mem_read,
    input  ex_mem_rd_addr, ex_mem_reg_write, mem_wb_rd_addr, mem_wb_reg_write,
    input  ex_branch_taken,
    output forward, pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard controller for a 5-stage RISC-V pipeline.
//
// - Per-operand EX forwarding selects (00 regfile, 01 EX/MEM, 10 MEM/WB).
// - Load-use stall FSM inserting LOAD_STALL_CY bubbles per hazard.
// - Branch/jump flush of IF/ID and ID/EX, overriding any stall.
//
// Ports:
//   clk   pipeline clock, rising edge
//   rst   asynchronous reset, active-high; holds controls in a safe flush state
//   bus   hazard_forward_ctrl_if.slave, all pipeline-side signals
//
// Optional build macro HAZARD_STATS_EN adds three 32-bit wrapping counters:
//   stat_stall_cycles  cycles with stall_active
//   stat_flushes       cycles with ex_branch_taken
//   stat_fwd_events    cycles in which any forward select is non-zero
module hazard_forward_ctrl #(
  parameter int unsigned REG_ADDR_W    = 5,
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned LOAD_STALL_CY = 1
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stat_stall_cycles,
  output logic [31:0]          stat_flushes,
  output logic [31:0]          stat_fwd_events
`endif
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StStall = 1'b1;

  // The entry cycle is itself the first bubble, so STALL covers the remainder.
  localparam logic [2:0] CntLoad = 3'(LOAD_STALL_CY - 1);

  logic [0:0]           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 hz;
  logic                 stall_int;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic                 fwd_any;

  // ---------------------------------------------------------------------------
  // Forwarding selects for the instruction in EX
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_raw = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      logic [REG_ADDR_W-1:0] rs;
      rs = bus.id_ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
      if (bus.ex_mem_reg_write && (bus.ex_mem_rd_addr != '0) && (bus.ex_mem_rd_addr == rs)) begin
        fwd_raw[2*i +: 2] = 2'b01;
      end else if (bus.mem_wb_reg_write && (bus.mem_wb_rd_addr != '0) &&
                   (bus.mem_wb_rd_addr == rs)) begin
        fwd_raw[2*i +: 2] = 2'b10;
      end
    end
  end

  assign fwd_any = |fwd_raw;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection against the instruction in ID
  // ---------------------------------------------------------------------------
  always_comb begin
    hz = 1'b0;
    if (bus.id_ex_mem_read && (bus.id_ex_rd_addr != '0)) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (bus.id_rs_used[i] &&
            (bus.id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W] == bus.id_ex_rd_addr)) begin
          hz = 1'b1;
        end
      end
    end
  end

  assign stall_int = (state_q == StStall) ||
                     ((state_q == StIdle) && hz && !bus.ex_branch_taken);

  // ---------------------------------------------------------------------------
  // Stall FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.ex_branch_taken) begin
      // Redirect squashes the stalled instruction, so the stall is abandoned.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (hz && (LOAD_STALL_CY > 1)) begin
            state_d = StStall;
            cnt_d   = CntLoad;
          end
        end
        StStall: begin
          // hz is not consulted here: the bubbles already in flight cover it.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline controls
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.forward      = fwd_raw;
    bus.stall_active = stall_int;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    if (rst) begin
      // Hold the front end and keep bubbles in the pipe until reset releases.
      bus.forward      = '0;
      bus.stall_active = 1'b0;
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // Keep PC and IF/ID writable so the redirect target is fetched.
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (stall_int) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
      stat_fwd_events   <= '0;
    end else begin
      if (stall_int) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
      if (bus.ex_branch_taken) begin
        stat_flushes <= stat_flushes + 32'd1;
      end
      if (fwd_any) begin
        stat_fwd_events <= stat_fwd_events + 32'd1;
      end
    end
  end
`else
  logic unused_fwd_any;
  assign unused_fwd_any = fwd_any;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed self-checking bench for hazard_forward_ctrl (NUM_SRC=2, LOAD_STALL_CY=3).
module tb_hazard_forward_ctrl;

  localparam int unsigned W  = 5;
  localparam int unsigned NS = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  hazard_forward_ctrl_if #(.REG_ADDR_W(W), .NUM_SRC(NS)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles;
  logic [31:0] stat_flushes;
  logic [31:0] stat_fwd_events;
`endif

  hazard_forward_ctrl #(
    .REG_ADDR_W   (W),
    .NUM_SRC      (NS),
    .LOAD_STALL_CY(3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cycles(stat_stall_cycles),
    .stat_flushes     (stat_flushes),
    .stat_fwd_events  (stat_fwd_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.id_rs_addr       = '0;
    bus.id_rs_used       = '0;
    bus.id_ex_rs_addr    = '0;
    bus.id_ex_rd_addr    = '0;
    bus.id_ex_mem_read   = 1'b0;
    bus.ex_mem_rd_addr   = '0;
    bus.ex_mem_reg_write = 1'b0;
    bus.mem_wb_rd_addr   = '0;
    bus.mem_wb_reg_write = 1'b0;
    bus.ex_branch_taken  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Load with rd=7 in EX, ID operand 1 reads x7.
  task automatic set_load_use();
    bus.id_ex_mem_read = 1'b1;
    bus.id_ex_rd_addr  = 5'd7;
    bus.id_rs_addr     = {5'd7, 5'd3};
    bus.id_rs_used     = 2'b10;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.id_ex_rs_addr    = {5'd2, 5'd1};
    bus.ex_mem_rd_addr   = 5'd1;
    bus.ex_mem_reg_write = 1'b1;
    #2;
    n_tests++;
    if (bus.forward !== 4'b0000) begin
      $display("FAIL reset_forward: got %b want 0000", bus.forward); n_fail++;
    end
    n_tests++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.stall_active}
        !== 5'b00110) begin
      $display("FAIL reset_ctrl: got %b want 00110",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                bus.stall_active});
      n_fail++;
    end
`ifdef HAZARD_STATS_EN
    n_tests++;
    if ({stat_stall_cycles, stat_flushes, stat_fwd_events} !== 96'd0) begin
      $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0",
               stat_stall_cycles, stat_flushes, stat_fwd_events);
      n_fail++;
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    n_tests++;
    if ({bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.stall_active}
        !== 5'b11000) begin
      $display("FAIL post_reset_idle: got %b want 11000",
               {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                bus.stall_active});
      n_fail++;
    end
  endtask

  task automatic test_forward();
    next_cycle();
    clear_inputs();
    // No match anywhere.
    bus.id_ex_rs_addr    = {5'd2, 5'd1};
    bus.ex_mem_rd_addr   = 5'd3;
    bus.ex_mem_reg_write = 1'b1;
    bus.mem_wb_rd_addr   = 5'd4;
    bus.mem_wb_reg_write = 1'b1;
    #1;
    n_tests++;
    if (bus.forward !== 4'b0000) begin
      $display("FAIL fwd_none: got %b want 0000", bus.forward); n_fail++;
    end
    // Both stages match rs0: EX/MEM wins.
    bus.id_ex_rs_addr  = {5'd8, 5'd5};
    bus.ex_mem_rd_addr = 5'd5;
    bus.mem_wb_rd_addr = 5'd5;
    #1;
    n_tests++;
    if (bus.forward !== 4'b0001) begin
      $display("FAIL fwd_ex_priority: got %b want 0001", bus.forward); n_fail++;
    end
    // x0 is never forwarded.
    bus.id_ex_rs_addr  = {5'd0, 5'd0};
    bus.ex_mem_rd_addr = 5'd0;
    bus.mem_wb_rd_addr = 5'd0;
    #1;
    n_tests++;
    if (bus.forward !== 4'b0000) begin
      $display("FAIL fwd_x0: got %b want 0000", bus.forward); n_fail++;
    end
    // MEM/WB match on rs1; EX/MEM matches too but is not writing.
    bus.id_ex_rs_addr    = {5'd9, 5'd1};
    bus.ex_mem_rd_addr   = 5'd9;
    bus.ex_mem_reg_write = 1'b0;
    bus.mem_wb_rd_addr   = 5'd9;
    #1;
    n_tests++;
    if (bus.forward !== 4'b1000) begin
      $display("FAIL fwd_memwb: got %b want 1000", bus.forward); n_fail++;
    end
    // rs0 from EX/MEM, rs1 from MEM/WB.
    bus.id_ex_rs_addr    = {5'd7, 5'd6};
    bus.ex_mem_rd_addr   = 5'd6;
    bus.ex_mem_reg_write = 1'b1;
    bus.mem_wb_rd_addr   = 5'd7;
    #1;
    n_tests++;
    if (bus.forward !== 4'b1001) begin
      $display("FAIL fwd_split: got %b want 1001", bus.forward); n_fail++;
    end
    // MEM/WB not writing: nothing forwarded for rs1.
    bus.mem_wb_reg_write = 1'b0;
    #1;
    n_tests++;
    if (bus.forward !== 4'b0001) begin
      $display("FAIL fwd_memwb_nowrite: got %b want 0001", bus.forward); n_fail++;
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    clear_inputs();
    set_load_use();
    #1;
    for (int c = 1; c <= 3; c++) begin
      n_tests++;
      if ({bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.if_id_flush, bus.stall_active}
          !== 5'b00101) begin
        $display("FAIL load_use_stall_c%0d: got %b want 00101", c,
                 {bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.if_id_flush,
                  bus.stall_active});
        n_fail++;
      end
      next_cycle();
      // Bubble now sits in EX; the hazard input drops.
      bus.id_ex_mem_read = 1'b0;
      #1;
    end
    n_tests++;
    if ({bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.stall_active} !== 4'b1100) begin
      $display("FAIL load_use_release: got %b want 1100",
               {bus.pc_write, bus.if_id_write, bus.id_ex_flush, bus.stall_active});
      n_fail++;
    end
  endtask

  task automatic test_no_use();
    next_cycle();
    clear_inputs();
    set_load_use();
    bus.id_rs_used = 2'b01;
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active, bus.id_ex_flush} !== 3'b100) begin
      $display("FAIL no_use_operand: got %b want 100",
               {bus.pc_write, bus.stall_active, bus.id_ex_flush});
      n_fail++;
    end
    // Load to x0 never stalls.
    bus.id_rs_used    = 2'b11;
    bus.id_ex_rd_addr = 5'd0;
    bus.id_rs_addr    = {5'd0, 5'd0};
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active} !== 2'b10) begin
      $display("FAIL no_use_x0: got %b want 10", {bus.pc_write, bus.stall_active});
      n_fail++;
    end
    // Hazard on operand 0 alone.
    bus.id_ex_rd_addr = 5'd12;
    bus.id_rs_addr    = {5'd3, 5'd12};
    bus.id_rs_used    = 2'b01;
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active} !== 2'b01) begin
      $display("FAIL hazard_op0: got %b want 01", {bus.pc_write, bus.stall_active});
      n_fail++;
    end
    // Branch in the same cycle suppresses the stall entry.
    bus.ex_branch_taken = 1'b1;
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active, bus.if_id_flush, bus.id_ex_flush} !== 4'b1011) begin
      $display("FAIL hazard_vs_branch: got %b want 1011",
               {bus.pc_write, bus.stall_active, bus.if_id_flush, bus.id_ex_flush});
      n_fail++;
    end
    next_cycle();
    clear_inputs();
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active} !== 2'b10) begin
      $display("FAIL hazard_vs_branch_next: got %b want 10", {bus.pc_write, bus.stall_active});
      n_fail++;
    end
  endtask

  task automatic test_branch_flush();
    next_cycle();
    clear_inputs();
    set_load_use();
    #1;
    next_cycle();
    bus.id_ex_mem_read  = 1'b0;
    bus.ex_branch_taken = 1'b1;
    #1;
    n_tests++;
    if ({bus.if_id_flush, bus.id_ex_flush, bus.pc_write, bus.if_id_write} !== 4'b1111) begin
      $display("FAIL branch_in_stall: got %b want 1111",
               {bus.if_id_flush, bus.id_ex_flush, bus.pc_write, bus.if_id_write});
      n_fail++;
    end
    next_cycle();
    bus.ex_branch_taken = 1'b0;
    #1;
    n_tests++;
    if ({bus.stall_active, bus.pc_write, bus.if_id_flush, bus.id_ex_flush} !== 4'b0100) begin
      $display("FAIL branch_after_stall: got %b want 0100",
               {bus.stall_active, bus.pc_write, bus.if_id_flush, bus.id_ex_flush});
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_stall();
    next_cycle();
    clear_inputs();
    set_load_use();
    #1;
    next_cycle();
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_rs_addr    = {5'd4, 5'd4};
    bus.ex_mem_rd_addr   = 5'd4;
    bus.ex_mem_reg_write = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.forward, bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
         bus.stall_active} !== 9'b0000_00110) begin
      $display("FAIL reset_mid_stall: got %b want 000000110",
               {bus.forward, bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
                bus.stall_active});
      n_fail++;
    end
`ifdef HAZARD_STATS_EN
    n_tests++;
    if ({stat_stall_cycles, stat_flushes, stat_fwd_events} !== 96'd0) begin
      $display("FAIL reset_mid_stall_stats: got %0d %0d %0d want 0 0 0",
               stat_stall_cycles, stat_flushes, stat_fwd_events);
      n_fail++;
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    n_tests++;
    if ({bus.pc_write, bus.stall_active, bus.id_ex_flush} !== 3'b100) begin
      $display("FAIL reset_release_idle: got %b want 100",
               {bus.pc_write, bus.stall_active, bus.id_ex_flush});
      n_fail++;
    end
    next_cycle();
    n_tests++;
    if ({bus.pc_write, bus.stall_active} !== 2'b10) begin
      $display("FAIL reset_release_next: got %b want 10", {bus.pc_write, bus.stall_active});
      n_fail++;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_no_use();
    test_branch_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
